// File: rtl/flappy_engine.sv
// Frame-ticked Flappy Bird game core: bird physics, scrolling pipes with random
// gaps, collision, IDLE/PLAY/DEAD round control and score/high-score tracking.
module flappy_engine #(
    parameter int N_PIPES      = 2,
    parameter int X_W          = 11,
    parameter int Y_W          = 10,
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int BIRD_X       = 100,
    parameter int BIRD_W       = 16,
    parameter int BIRD_H       = 16,
    parameter int PIPE_W       = 40,
    parameter int PIPE_SPACING = 320,
    parameter int SCROLL       = 2,
    parameter int GAP_H        = 120,
    parameter int GAP_MIN      = 40,
    parameter int FLAP_V       = 6,
    parameter int GRAVITY      = 1,
    parameter int VMAX         = 8,
    parameter int TICK_DIV     = 833333,
    parameter int SCORE_W      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flap,
    output logic                     frame_tick,
    output logic [1:0]               state,
    output logic [Y_W-1:0]           bird_y,
    output logic [N_PIPES*X_W-1:0]   pipe_x,
    output logic [N_PIPES*Y_W-1:0]   pipe_gap,
    output logic [SCORE_W-1:0]       score,
    output logic [SCORE_W-1:0]       hi_score
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DEAD = 2'b10
    } state_e;

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int VEL_W = 8;
    localparam int Y_TOP = SCREEN_H - BIRD_H;

    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      frame_tick_q, frame_tick_d;
    logic                      flap_prev_q, flap_pend_q, flap_pend_d, flap_rise;
    logic [15:0]               lfsr_q, lfsr_d;
    state_e                    state_q, state_d;
    logic [Y_W-1:0]            y_q, y_d;
    logic signed [VEL_W-1:0]   vel_q, vel_d;
    logic [X_W-1:0]            x_q [N_PIPES];
    logic [X_W-1:0]            x_d [N_PIPES];
    logic [X_W-1:0]            x_play [N_PIPES];
    logic [Y_W-1:0]            gap_q [N_PIPES];
    logic [Y_W-1:0]            gap_d [N_PIPES];
    logic [Y_W-1:0]            gap_play [N_PIPES];
    logic [SCORE_W-1:0]        score_q, score_d, score_play, hi_q, hi_d;
    int                        vel_n, y_n, x_old, x_n, gap_n;
    logic                      passed, hit, die;

    function automatic logic [X_W-1:0] init_x(input int i);
        return X_W'(SCREEN_W + i * PIPE_SPACING);
    endfunction

    function automatic logic [Y_W-1:0] init_gap(input int i);
        return Y_W'(GAP_MIN + 64 * i);
    endfunction

    // A rising edge seen on the tick cycle itself survives into the next frame.
    always_comb begin
        cnt_d        = (cnt_q == CNT_W'(TICK_DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
        frame_tick_d = (cnt_d == CNT_W'(TICK_DIV - 1));
        flap_rise    = flap & ~flap_prev_q;
        flap_pend_d  = frame_tick_q ? flap_rise : (flap_pend_q | flap_rise);
        lfsr_d       = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    // One PLAY frame computed from the current state, in signed int arithmetic.
    always_comb begin
        // NOTE: every variable is given a value before any branch so no latch is inferred.
        passed = 1'b0;
        hit    = 1'b0;
        x_old  = 0;
        x_n    = 0;
        gap_n  = 0;
        if (flap_pend_q)
            vel_n = FLAP_V;
        else if (int'(vel_q) - GRAVITY < -VMAX)
            vel_n = -VMAX;
        else
            vel_n = int'(vel_q) - GRAVITY;
        y_n = int'(y_q) + vel_n;
        if (y_n < 0) begin
            y_n = 0;
        end else if (y_n > Y_TOP) begin
            y_n   = Y_TOP;
            vel_n = 0;
        end
        for (int i = 0; i < N_PIPES; i++) begin
            x_old = int'(x_q[i]);
            if (x_old <= SCROLL) begin
                x_n   = x_old - SCROLL + N_PIPES * PIPE_SPACING;
                gap_n = GAP_MIN + int'(lfsr_q[7:0]);
            end else begin
                x_n   = x_old - SCROLL;
                gap_n = int'(gap_q[i]);
            end
            x_play[i]   = X_W'(x_n);
            gap_play[i] = Y_W'(gap_n);
            if (x_old + PIPE_W >= BIRD_X && x_n + PIPE_W < BIRD_X)
                passed = 1'b1;
            if (x_n < BIRD_X + BIRD_W && x_n + PIPE_W > BIRD_X &&
                (y_n < gap_n || y_n + BIRD_H > gap_n + GAP_H))
                hit = 1'b1;
        end
        score_play = (passed && score_q != '1) ? score_q + SCORE_W'(1) : score_q;
        die        = (y_n == 0) || hit;
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        vel_d   = vel_q;
        x_d     = x_q;
        gap_d   = gap_q;
        score_d = score_q;
        hi_d    = hi_q;
        if (frame_tick_q) begin
            case (state_q)
                ST_IDLE, ST_PLAY: begin
                    if (state_q == ST_PLAY || flap_pend_q) begin
                        y_d     = Y_W'(y_n);
                        vel_d   = VEL_W'(vel_n);
                        x_d     = x_play;
                        gap_d   = gap_play;
                        score_d = score_play;
                        state_d = die ? ST_DEAD : ST_PLAY;
                        if (die && score_play > hi_q)
                            hi_d = score_play;
                    end
                end
                ST_DEAD: begin
                    if (flap_pend_q) begin
                        state_d = ST_IDLE;
                        y_d     = Y_W'(SCREEN_H / 2);
                        vel_d   = '0;
                        score_d = '0;
                        for (int i = 0; i < N_PIPES; i++) begin
                            x_d[i]   = init_x(i);
                            gap_d[i] = init_gap(i);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            frame_tick_q <= 1'b0;
            flap_prev_q  <= 1'b0;
            flap_pend_q  <= 1'b0;
            lfsr_q       <= 16'hACE1;
            state_q      <= ST_IDLE;
            y_q          <= Y_W'(SCREEN_H / 2);
            vel_q        <= '0;
            score_q      <= '0;
            hi_q         <= '0;
            for (int i = 0; i < N_PIPES; i++) begin
                x_q[i]   <= init_x(i);
                gap_q[i] <= init_gap(i);
            end
        end else begin
            cnt_q        <= cnt_d;
            frame_tick_q <= frame_tick_d;
            flap_prev_q  <= flap;
            flap_pend_q  <= flap_pend_d;
            lfsr_q       <= lfsr_d;
            state_q      <= state_d;
            y_q          <= y_d;
            vel_q        <= vel_d;
            x_q          <= x_d;
            gap_q        <= gap_d;
            score_q      <= score_d;
            hi_q         <= hi_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N_PIPES; i++) begin
            pipe_x[i*X_W +: X_W]   = x_q[i];
            pipe_gap[i*Y_W +: Y_W] = gap_q[i];
        end
    end

    assign frame_tick = frame_tick_q;
    assign state      = state_q;
    assign bird_y     = y_q;
    assign score      = score_q;
    assign hi_score   = hi_q;

endmodule
